// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Write-side scheduler for the asynchronous FIFO. It shares the single FIFO
// write port among REQ producers in the write clock domain. Grants are handed
// out round-robin in bursts of up to BURST beats. The full flag stalls a burst
// that is in progress. The almost-full flag only prevents new grants.
//
// Ports
//   write_clock       in   single clock, rising edge
//   reset             in   asynchronous, active-high
//   req_valid[REQ]    in   per-requester beat available
//   req_data          in   requester i data in bits [i*WIDTH +: WIDTH]
//   req_last[REQ]     in   current beat ends the requester's packet
//   req_ready[REQ]    out  beat of requester i accepted this cycle
//   full_flag         in   FIFO full
//   almost_full_flag  in   FIFO almost full
//   valid_write       out  write strobe to FIFO write counter / RAM
//   write_data        out  beat data to FIFO RAM
//   grant_id          out  current owner index (registered)
//   busy              out  high while a grant is held
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
   parameter int WIDTH = 8,
   parameter int REQ   = 4,
   parameter int BURST = 4
) (
   input  logic                     write_clock,
   input  logic                     reset,
   input  logic [REQ-1:0]           req_valid,
   input  logic [REQ*WIDTH-1:0]     req_data,
   input  logic [REQ-1:0]           req_last,
   output logic [REQ-1:0]           req_ready,
   input  logic                     full_flag,
   input  logic                     almost_full_flag,
   output logic                     valid_write,
   output logic [WIDTH-1:0]         write_data,
   output logic [$clog2(REQ)-1:0]   grant_id,
   output logic                     busy
);

   localparam int IDW  = $clog2(REQ);
   localparam int CNTW = $clog2(BURST + 1);

   typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [IDW-1:0]    grant_id_q, grant_id_d;
   logic [IDW-1:0]    last_id_q, last_id_d;
   logic [CNTW-1:0]   beat_cnt_q, beat_cnt_d;

   logic [WIDTH-1:0]  data_arr [REQ];
   logic              found;
   logic [IDW-1:0]    winner;
   logic              accept;
   logic [CNTW-1:0]   cnt_inc;
   logic              burst_end;

   always_comb begin
      for (int i = 0; i < REQ; i++) begin
         data_arr[i] = req_data[i*WIDTH +: WIDTH];
      end
   end

   // Round-robin search: the first valid requester after last_id_q, wrapping
   // modulo REQ. last_id_q itself is checked last.
   always_comb begin
      logic [IDW-1:0] sel;
      int             idx;
      found  = 1'b0;
      winner = '0;
      sel    = '0;
      idx    = 0;
      for (int k = 1; k <= REQ; k++) begin
         idx = int'(last_id_q) + k;
         if (idx >= REQ) idx = idx - REQ;
         sel = idx[IDW-1:0];
         if (!found && req_valid[sel]) begin
            found  = 1'b1;
            winner = sel;
         end
      end
   end

   assign accept    = (state_q == XFER) && req_valid[grant_id_q] && !full_flag;
   assign cnt_inc   = beat_cnt_q + CNTW'(1);
   assign burst_end = (cnt_inc == CNTW'(BURST));

   always_comb begin
      state_d     = state_q;
      grant_id_d  = grant_id_q;
      last_id_d   = last_id_q;
      beat_cnt_d  = beat_cnt_q;
      valid_write = 1'b0;
      req_ready   = '0;
      case (state_q)
         IDLE: begin
            if (found && !almost_full_flag) begin
               grant_id_d = winner;
               last_id_d  = winner;
               beat_cnt_d = '0;
               state_d    = XFER;
            end
         end
         XFER: begin
            // Ready follows only the full flag. The beat is consumed when the
            // owner is also valid, which is exactly when valid_write is high.
            req_ready[grant_id_q] = !full_flag;
            valid_write           = accept;
            if (accept) beat_cnt_d = cnt_inc;
            if ((accept && (req_last[grant_id_q] || burst_end)) ||
                !req_valid[grant_id_q]) begin
               state_d    = IDLE;
               beat_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge write_clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_id_q <= '0;
         last_id_q  <= IDW'(REQ - 1);
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         last_id_q  <= last_id_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign write_data = data_arr[grant_id_q];
   assign grant_id   = grant_id_q;
   assign busy       = (state_q == XFER);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Directed bench for fifo_write_arbiter (WIDTH=8, REQ=4, BURST=4). Inputs
// change 1 time unit after a rising edge. Outputs are checked 1 unit later,
// well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

   localparam int WIDTH = 8;
   localparam int REQ   = 4;
   localparam int BURST = 4;

   logic                   clk;
   logic                   rst;
   logic [REQ-1:0]         req_valid;
   logic [REQ*WIDTH-1:0]   req_data;
   logic [REQ-1:0]         req_last;
   logic [REQ-1:0]         req_ready;
   logic                   full_flag;
   logic                   almost_full_flag;
   logic                   valid_write;
   logic [WIDTH-1:0]       write_data;
   logic [1:0]             grant_id;
   logic                   busy;

   int n_cmp = 0;
   int n_err = 0;

   fifo_write_arbiter #(.WIDTH(WIDTH), .REQ(REQ), .BURST(BURST)) dut (
      .write_clock      (clk),
      .reset            (rst),
      .req_valid        (req_valid),
      .req_data         (req_data),
      .req_last         (req_last),
      .req_ready        (req_ready),
      .full_flag        (full_flag),
      .almost_full_flag (almost_full_flag),
      .valid_write      (valid_write),
      .write_data       (write_data),
      .grant_id         (grant_id),
      .busy             (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int i, input logic v, input logic [7:0] d, input logic l);
      req_valid[i]          = v;
      req_data[i*WIDTH +: WIDTH] = d;
      req_last[i]           = l;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks one write cycle from the given owner carrying the given data.
   task automatic chk_beat(input string tag, input logic [1:0] id, input logic [7:0] d);
      #1;
      chk({tag, " busy"},  32'(busy), 32'd1);
      chk({tag, " grant"}, 32'(grant_id), 32'(id));
      chk({tag, " vw"},    32'(valid_write), 32'd1);
      chk({tag, " data"},  32'(write_data), 32'(d));
      chk({tag, " ready"}, 32'(req_ready), 32'(4'b0001 << id));
   endtask

   task automatic chk_idle(input string tag);
      #1;
      chk({tag, " busy"},  32'(busy), 32'd0);
      chk({tag, " vw"},    32'(valid_write), 32'd0);
      chk({tag, " ready"}, 32'(req_ready), 32'd0);
   endtask

   initial begin
      logic [1:0] order [5];
      order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd3; order[3] = 2'd0; order[4] = 2'd1;

      rst              = 1'b1;
      req_valid        = '0;
      req_data         = '0;
      req_last         = '0;
      full_flag        = 1'b0;
      almost_full_flag = 1'b0;
      req_data[7:0]    = 8'h5A;

      // Reset state
      #12;
      chk_idle("reset");
      chk("reset grant", 32'(grant_id), 32'd0);
      chk("reset data",  32'(write_data), 32'h5A);
      tick();
      rst = 1'b0;

      // Requester 0 alone: A1, A2, A3 (last)
      tick();
      drv(0, 1'b1, 8'hA1, 1'b0);
      chk_idle("t1 pre");
      tick();
      chk_beat("t1 A1", 2'd0, 8'hA1);
      tick();
      drv(0, 1'b1, 8'hA2, 1'b0);
      chk_beat("t1 A2", 2'd0, 8'hA2);
      tick();
      drv(0, 1'b1, 8'hA3, 1'b1);
      chk_beat("t1 A3", 2'd0, 8'hA3);
      tick();
      drv(0, 1'b0, 8'h00, 1'b0);
      chk_idle("t1 end");

      // All valid, last on every beat: owner 0 was last, so 1,2,3,0,1
      for (int i = 0; i < REQ; i++) drv(i, 1'b1, 8'(8'h10 + i), 1'b1);
      for (int g = 0; g < 5; g++) begin
         tick();
         chk_beat("t2 grant", order[g], 8'(8'h10 + order[g]));
         tick();
         chk_idle("t2 bubble");
      end
      for (int i = 0; i < REQ; i++) drv(i, 1'b0, 8'h00, 1'b0);

      // Requester 2 offers 6 beats, no last: 4 beats, then 3, then 2 resumes
      tick();
      drv(2, 1'b1, 8'h21, 1'b0);
      drv(3, 1'b1, 8'h31, 1'b1);
      tick();
      chk_beat("t3 b1", 2'd2, 8'h21);
      tick();
      drv(2, 1'b1, 8'h22, 1'b0);
      chk_beat("t3 b2", 2'd2, 8'h22);
      tick();
      drv(2, 1'b1, 8'h23, 1'b0);
      chk_beat("t3 b3", 2'd2, 8'h23);
      tick();
      drv(2, 1'b1, 8'h24, 1'b0);
      chk_beat("t3 b4", 2'd2, 8'h24);
      tick();
      drv(2, 1'b1, 8'h25, 1'b0);
      chk_idle("t3 burst end");
      tick();
      chk_beat("t3 r3", 2'd3, 8'h31);
      tick();
      drv(3, 1'b0, 8'h00, 1'b0);
      chk_idle("t3 bubble");
      tick();
      chk_beat("t3 b5", 2'd2, 8'h25);
      tick();
      drv(2, 1'b1, 8'h26, 1'b1);
      chk_beat("t3 b6", 2'd2, 8'h26);
      tick();
      drv(2, 1'b0, 8'h00, 1'b0);
      chk_idle("t3 end");

      // Full for 5 cycles mid-burst; stall must not advance the beat count
      drv(1, 1'b1, 8'h41, 1'b0);
      tick();
      chk_beat("t4 b1", 2'd1, 8'h41);
      tick();
      drv(1, 1'b1, 8'h42, 1'b0);
      chk_beat("t4 b2", 2'd1, 8'h42);
      tick();
      drv(1, 1'b1, 8'h43, 1'b0);
      full_flag = 1'b1;
      for (int s = 0; s < 5; s++) begin
         #1;
         chk("t4 stall vw",    32'(valid_write), 32'd0);
         chk("t4 stall ready", 32'(req_ready), 32'd0);
         chk("t4 stall busy",  32'(busy), 32'd1);
         chk("t4 stall grant", 32'(grant_id), 32'd1);
         tick();
      end
      full_flag = 1'b0;
      chk_beat("t4 b3", 2'd1, 8'h43);
      tick();
      drv(1, 1'b1, 8'h44, 1'b0);
      chk_beat("t4 b4", 2'd1, 8'h44);
      tick();
      drv(1, 1'b0, 8'h00, 1'b0);
      chk_idle("t4 end");

      // Almost full blocks new grants only; last owner 1, so 0 wins
      almost_full_flag = 1'b1;
      drv(0, 1'b1, 8'h50, 1'b0);
      for (int s = 0; s < 3; s++) begin
         tick();
         chk_idle("t5 blocked");
      end
      almost_full_flag = 1'b0;
      tick();
      chk_beat("t5 b1", 2'd0, 8'h50);
      almost_full_flag = 1'b1;
      tick();
      drv(0, 1'b1, 8'h51, 1'b1);
      chk_beat("t5 b2", 2'd0, 8'h51);
      tick();
      drv(0, 1'b0, 8'h00, 1'b0);
      almost_full_flag = 1'b0;
      chk_idle("t5 end");

      // Reset during beat 2; afterwards 0 must beat 3 (pointer restored)
      drv(0, 1'b1, 8'h70, 1'b0);
      drv(2, 1'b1, 8'h61, 1'b0);
      drv(3, 1'b1, 8'h80, 1'b0);
      tick();
      chk_beat("t6 b1", 2'd2, 8'h61);
      tick();
      drv(2, 1'b1, 8'h62, 1'b0);
      chk_beat("t6 b2", 2'd2, 8'h62);
      rst = 1'b1;
      chk_idle("t6 reset");
      chk("t6 reset grant", 32'(grant_id), 32'd0);
      tick();
      rst = 1'b0;
      chk_idle("t6 released");
      tick();
      chk_beat("t6 first", 2'd0, 8'h70);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Write-side scheduler for the asynchronous FIFO: shares the single FIFO write port among REQ independent producers, all in the write clock domain. Grants the port round-robin in bursts, drives the FIFO's write-valid and write-data, and honours the FIFO's full and almost-full flags so that no beat is lost or duplicated. Sits directly in front of the FIFO write side: its `valid_write` feeds the write counter's valid input, and the flags come back from the full generator.

## Interface
- `WIDTH`, 8: data width of one beat.
- `REQ`, 4: number of requesters, at least 2.
- `BURST`, 4: maximum beats per grant, at least 1.
- `write_clock`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  REQ: per-requester "beat available".
- `req_data`  in  REQ*WIDTH: requester i data in bits [i*WIDTH +: WIDTH].
- `req_last`  in  REQ: the current beat is the last of the requester's packet.
- `req_ready`  out  REQ: beat of requester i is accepted this cycle.
- `full_flag`  in  1: FIFO full, from the full generator.
- `almost_full_flag`  in  1: FIFO almost full, from the full generator.
- `valid_write`  out  1: write strobe to the FIFO write counter and RAM.
- `write_data`  out  WIDTH: data to the FIFO RAM.
- `grant_id`  out  clog2(REQ): current owner index (registered).
- `busy`  out  1: high while a grant is held (state XFER).

## Operation
- The state machine has two states, IDLE and XFER.
- Registers:
  - `state`.
  - `grant_id`.
  - `last_id`: previous owner, the round-robin pointer.
  - `beat_cnt`: clog2(BURST+1) bits.
- IDLE:
  - If any `req_valid` is set and `almost_full_flag` is 0, grant the first requester with `req_valid` set, searching upward from `last_id`+1 modulo REQ.
  - On a grant: `grant_id` and `last_id` take the winner, `beat_cnt` is cleared to 0, and the next state is XFER.
  - Otherwise stay in IDLE.
  - No beats transfer in IDLE.
- XFER, with owner o = `grant_id`:
  - `accept` = `req_valid[o]` & ~`full_flag`.
  - `valid_write` = `accept`.
  - `write_data` = `req_data[o]`.
  - `req_ready[o]` = ~`full_flag`. All other `req_ready` bits are 0.
  - On `accept`, `beat_cnt` increments.
  - Release to IDLE at the end of the cycle when any of these holds:
    - `accept` & `req_last[o]`;
    - `accept` & (`beat_cnt`+1 == BURST);
    - `req_valid[o]` == 0 (the owner has gone idle).
  - `full_flag` high with `req_valid[o]` high: hold the grant and stall. The stall is unbounded, with no timeout.
  - `almost_full_flag` does not interrupt a grant in progress; it only blocks new grants in IDLE.
- Wrap-around:
  - The round-robin search index wraps modulo REQ.
  - `beat_cnt` never exceeds BURST-1 while in XFER.
- Simultaneous release and new request: the release always passes through IDLE, so back-to-back grants have a 1-cycle bubble.
- `valid_write` and `req_ready` are combinational from registered state and the current inputs. The FIFO's write counter samples them at the same edge, so a beat is consumed exactly once.

## Timing
- Reset values, applied immediately on `reset`:
  - `state` = IDLE, `grant_id` = 0, `last_id` = REQ-1 (requester 0 has first priority), `beat_cnt` = 0.
  - `busy` = 0, `valid_write` = 0, `req_ready` = 0, `write_data` = `req_data[0]` (don't-care while `valid_write` is 0).
- Reset asserted mid-burst: the grant is dropped immediately and `valid_write` falls in the same cycle. No partial state survives.
- Grant latency: a request seen at edge N gives `busy`=1 and a valid `grant_id` after edge N, and the first beat can be accepted in cycle N+1.
- Throughput: 1 beat per cycle while `req_valid[o]` is high and `full_flag` is low. Peak throughput is BURST beats per BURST+1 cycles.
- `full_flag` assertion blocks acceptance in the same cycle, with zero-cycle reaction.

## Test plan
- Requester 0 alone sends 3 beats A1, A2, A3 with `req_last` on A3 → `valid_write` high for exactly 3 consecutive cycles carrying A1..A3, then `busy` falls; `grant_id` = 0 throughout.
- All 4 requesters continuously valid with `req_last`=1 on every beat → grant order 0, 1, 2, 3, 0, …, one beat per grant, with one IDLE bubble between grants.
- BURST=4, requester 2 offers 6 beats with no `req_last` → 4 beats written, release, then other requesters are served, then requester 2 resumes with beat 5.
- `full_flag` forced high for 5 cycles mid-burst → `valid_write` and `req_ready` stay 0 for those 5 cycles, the grant is held, and no beat is dropped or duplicated in the FIFO write stream.
- `almost_full_flag` high while IDLE with requests pending → no grant and `busy` stays 0. Deasserting it → grant on the next edge.
- `reset` pulsed during beat 2 of a burst → `valid_write` = 0 and `busy` = 0 immediately. After release, requester 0 wins first arbitration.
